// File: rtl/ann_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : ann_input_loader
// Brief    : Streams a 16-bit word sequence into the ANN image vector and the
//            weight matrix, and reloads weights on request for later layers.
// Revision : 1.0 - initial release
// ============================================================================
module ann_input_loader #(
  parameter int IMAGE_SIZE  = 64,
  parameter int FIRST_LAYER = 16,
  parameter int CNT_W       = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        request_coef,
  input  logic        coef_select,
  output logic [15:0] image   [IMAGE_SIZE],
  output logic [15:0] weights [FIRST_LAYER][IMAGE_SIZE],
  output logic        image_weights_loaded,
  output logic        coef_loaded,
  output logic        coef_bank,
  output logic        busy,
  output logic        err
);

  localparam int ROW_W = (FIRST_LAYER > 1) ? $clog2(FIRST_LAYER) : 1;
  localparam int COL_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam logic [CNT_W-1:0] C_IMG_LAST = CNT_W'(IMAGE_SIZE - 1);
  localparam logic [CNT_W-1:0] C_W_LAST   = CNT_W'(FIRST_LAYER * IMAGE_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD_IMG    = 3'd1,
    S_LOAD_W      = 3'd2,
    S_FRAME_DONE  = 3'd3,
    S_RELOAD_DONE = 3'd4,
    S_HOLD        = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reload_q, reload_d;
  logic             err_q, err_d;
  logic             bank_q, bank_d;
  logic             ready_q, iwl_q, cl_q, busy_q;
  logic             w_xfer, w_img_we, w_w_we;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;
  logic [15:0]      image_q   [IMAGE_SIZE];
  logic [15:0]      weights_q [FIRST_LAYER][IMAGE_SIZE];

  assign w_xfer = data_valid && ready_q;
  assign w_row  = ROW_W'(cnt_q / CNT_W'(IMAGE_SIZE));
  assign w_col  = COL_W'(cnt_q % CNT_W'(IMAGE_SIZE));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    err_d    = err_q;
    bank_d   = bank_q;
    w_img_we = 1'b0;
    w_w_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD_IMG;
          cnt_d    = '0;
          reload_d = 1'b0;
          bank_d   = 1'b0;
          err_d    = request_coef;
        end else if (request_coef) begin
          err_d = 1'b1;
        end
      end
      S_LOAD_IMG, S_LOAD_W: begin
        if (start) begin
          // Abort: restart the frame, leaving stale entries to be overwritten.
          state_d  = S_LOAD_IMG;
          cnt_d    = '0;
          reload_d = 1'b0;
          bank_d   = 1'b0;
          err_d    = 1'b1;
        end else begin
          if (request_coef) begin
            err_d = 1'b1;
          end
          if (w_xfer && (state_q == S_LOAD_IMG)) begin
            w_img_we = 1'b1;
            if (cnt_q == C_IMG_LAST) begin
              state_d = S_LOAD_W;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (w_xfer) begin
            w_w_we = 1'b1;
            if (cnt_q == C_W_LAST) begin
              state_d = reload_q ? S_RELOAD_DONE : S_FRAME_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      S_FRAME_DONE, S_RELOAD_DONE, S_HOLD: begin
        if (start) begin
          state_d  = S_LOAD_IMG;
          cnt_d    = '0;
          reload_d = 1'b0;
          bank_d   = 1'b0;
          err_d    = request_coef;
        end else if (request_coef && (state_q == S_HOLD)) begin
          state_d  = S_LOAD_W;
          cnt_d    = '0;
          reload_d = 1'b1;
          bank_d   = coef_select;
        end else begin
          if (request_coef) begin
            err_d = 1'b1;
          end
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      reload_q <= 1'b0;
      err_q    <= 1'b0;
      bank_q   <= 1'b0;
      ready_q  <= 1'b0;
      iwl_q    <= 1'b0;
      cl_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      err_q    <= err_d;
      bank_q   <= bank_d;
      ready_q  <= (state_d == S_LOAD_IMG) || (state_d == S_LOAD_W);
      iwl_q    <= (state_d == S_FRAME_DONE);
      cl_q     <= (state_d == S_RELOAD_DONE);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        image_q[i] <= '0;
      end
    end else if (w_img_we) begin
      image_q[w_col] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < FIRST_LAYER; r++) begin
        for (int c = 0; c < IMAGE_SIZE; c++) begin
          weights_q[r][c] <= '0;
        end
      end
    end else if (w_w_we) begin
      weights_q[w_row][w_col] <= data_in;
    end
  end

  assign image                = image_q;
  assign weights              = weights_q;
  assign data_ready           = ready_q;
  assign image_weights_loaded = iwl_q;
  assign coef_loaded          = cl_q;
  assign coef_bank            = bank_q;
  assign busy                 = busy_q;
  assign err                  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ann_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ann_input_loader
// Brief    : Self-checking bench for ann_input_loader against a word-indexed
//            array model of the image vector and weight matrix.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ann_input_loader;

  localparam int IMG = 64;
  localparam int NL  = 16;
  localparam int NW  = IMG * NL;
  localparam int TOT = IMG + NW;

  logic        clk = 1'b0;
  logic        rst, start, data_valid, request_coef, coef_select;
  logic [15:0] data_in;
  logic        data_ready, iwl, cl, coef_bank, busy, err;
  logic [15:0] image   [IMG];
  logic [15:0] weights [NL][IMG];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] img_m [IMG];
  logic [15:0] w_m   [NL][IMG];
  logic        err_m, bank_m;
  logic [15:0] src [$];
  int          pc;

  ann_input_loader #(.IMAGE_SIZE(IMG), .FIRST_LAYER(NL), .CNT_W(11)) u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .data_in              (data_in),
    .data_valid           (data_valid),
    .data_ready           (data_ready),
    .request_coef         (request_coef),
    .coef_select          (coef_select),
    .image                (image),
    .weights              (weights),
    .image_weights_loaded (iwl),
    .coef_loaded          (cl),
    .coef_bank            (coef_bank),
    .busy                 (busy),
    .err                  (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream word k of a frame: image words first, then weights row-major.
  task automatic put(input int k, input logic [15:0] w);
    if (k < IMG) img_m[k] = w;
    else         w_m[(k - IMG) / IMG][(k - IMG) % IMG] = w;
  endtask

  task automatic model_clear();
    for (int i = 0; i < IMG; i++) img_m[i] = '0;
    for (int r = 0; r < NL; r++)
      for (int c = 0; c < IMG; c++) w_m[r][c] = '0;
  endtask

  task automatic check_arrays(input string tag);
    for (int i = 0; i < IMG; i++)
      chk($sformatf("%s image[%0d]", tag, i), image[i], img_m[i]);
    for (int r = 0; r < NL; r++)
      for (int c = 0; c < IMG; c++)
        chk($sformatf("%s weights[%0d][%0d]", tag, r, c), weights[r][c], w_m[r][c]);
  endtask

  // mode 0: ascending image / 1000+ weights, 1: random, 2: constant 0x7FFF
  task automatic mk_src(input int n, input int mode);
    src.delete();
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       src.push_back(16'((i < IMG) ? i : 1000 + i - IMG));
        1:       src.push_back(16'($urandom));
        default: src.push_back(16'h7FFF);
      endcase
    end
  endtask

  // Called in the trigger cycle (cycle 1). Returns the cycle the pulse shows.
  task automatic feed(input int total, input int off, input int vmode,
                      input bit reload, output int pulse_cyc);
    int  pos;
    int  c;
    bit  v;
    bit  done;
    pos = 0; c = 1; done = 0; pulse_cyc = -1;
    while (!done) begin
      @(negedge clk);
      c++;
      start        = 1'b0;
      request_coef = 1'b0;
      if (pos == total) begin
        chk(reload ? "coef_loaded pulse" : "frame pulse", reload ? cl : iwl, 1);
        chk("other pulse", reload ? iwl : cl, 0);
        chk("ready at pulse", data_ready, 0);
        data_valid = 1'b0;
        pulse_cyc  = c;
        done       = 1;
      end else begin
        chk("ready while loading", data_ready, 1);
        chk("busy while loading", busy, 1);
        chk("no pulse while loading", {31'd0, iwl | cl}, 0);
        case (vmode)
          0:       v = 1'b1;
          1:       v = (c % 2 == 1);
          default: v = 1'($urandom_range(0, 1));
        endcase
        data_valid = v;
        data_in    = v ? src[pos] : 16'($urandom);
        if (v) begin
          put(off + pos, src[pos]);
          pos++;
        end
      end
    end
    @(negedge clk);
    chk("hold no frame pulse", iwl, 0);
    chk("hold no coef pulse", cl, 0);
    chk("hold busy", busy, 1);
    chk("hold ready", data_ready, 0);
    chk("err", err, err_m);
    chk("coef_bank", coef_bank, bank_m);
  endtask

  // n back-to-back transfers of src[0..n-1] as frame words; returns at a negedge.
  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; request_coef = 1'b0;
      data_valid = 1'b1; data_in = src[i];
      put(i, src[i]);
    end
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_valid = 1'b0; request_coef = 1'b0;
    coef_select = 1'b0; data_in = '0;
    model_clear(); err_m = 0; bank_m = 0;
    @(negedge clk); @(negedge clk);
    chk("reset ready", data_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset err", err, 0);
    chk("reset bank", coef_bank, 0);
    chk("reset pulses", {31'd0, iwl | cl}, 0);
    check_arrays("reset");
    rst = 1'b0;

    // Request in IDLE: flagged, no state change.
    @(negedge clk); request_coef = 1'b1;
    @(negedge clk); request_coef = 1'b0;
    chk("idle req err", err, 1);
    chk("idle req ready", data_ready, 0);
    chk("idle req busy", busy, 0);

    // Full frame, valid held high; start clears err.
    mk_src(TOT, 0); err_m = 0; bank_m = 0;
    start = 1'b1; data_valid = 1'b1; data_in = 16'hDEAD;
    chk("ready in start cycle", data_ready, 0);
    feed(TOT, 0, 0, 0, pc);
    chk("frame latency", pc, 1 + IMG + NW + 1);
    chk("image[5]", image[5], 16'd5);
    chk("weights[2][3]", weights[2][3], 16'd1131);
    check_arrays("frame1");

    // Random data, random valid.
    mk_src(TOT, 1);
    start = 1'b1;
    feed(TOT, 0, 2, 0, pc);
    check_arrays("frame_rand");

    // Same frame as the first, valid toggling every cycle.
    mk_src(TOT, 0);
    start = 1'b1; data_valid = 1'b1;
    feed(TOT, 0, 1, 0, pc);
    chk("toggle latency", pc, 1 + IMG + NW + 1 + 1088);
    check_arrays("frame_toggle");

    // Weight reload from HOLD, bank 1, all 0x7FFF.
    mk_src(NW, 2); bank_m = 1;
    request_coef = 1'b1; coef_select = 1'b1;
    feed(NW, IMG, 0, 1, pc);
    coef_select = 1'b0;
    chk("reload latency", pc, 1 + NW + 1);
    check_arrays("reload_7fff");

    // Random reload into bank 0 with random valid.
    mk_src(NW, 1); bank_m = 0;
    request_coef = 1'b1; coef_select = 1'b0;
    feed(NW, IMG, 2, 1, pc);
    check_arrays("reload_rand");

    // Bank 1 reload, then a start+request collision: start wins, err set, bank 0.
    mk_src(NW, 1); bank_m = 1;
    request_coef = 1'b1; coef_select = 1'b1;
    feed(NW, IMG, 0, 1, pc);
    coef_select = 1'b0;
    mk_src(TOT, 1); bank_m = 0; err_m = 1;
    start = 1'b1; request_coef = 1'b1;
    feed(TOT, 0, 0, 0, pc);
    check_arrays("collision");

    // Abort after 10 image words: restart overwrites from image[0].
    mk_src(TOT, 1); err_m = 0;
    start = 1'b1;
    push_words(10);
    chk("err before abort", err, 0);
    mk_src(TOT, 1); err_m = 1;
    start = 1'b1;
    feed(TOT, 0, 0, 0, pc);
    chk("abort latency", pc, 1 + IMG + NW + 1);
    check_arrays("abort");

    // Reset mid weight load, then a clean frame.
    mk_src(TOT, 1); err_m = 0;
    start = 1'b1;
    push_words(IMG + 500);
    rst = 1'b1; model_clear(); err_m = 0; bank_m = 0;
    #1;
    chk("async rst ready", data_ready, 0);
    chk("async rst busy", busy, 0);
    chk("async rst pulses", {31'd0, iwl | cl}, 0);
    check_arrays("async_rst");
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no pulse after rst", {31'd0, iwl | cl}, 0);
      chk("idle after rst", busy, 0);
    end
    mk_src(TOT, 1);
    start = 1'b1;
    feed(TOT, 0, 2, 0, pc);
    check_arrays("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ann_input_loader.md
Name: ann_input_loader

Overview:
- Upstream feeder for the ANN datapath.
- Accepts a 16-bit word stream (valid/ready) and assembles the image vector and the weight matrix into registered arrays.
- Asserts image_weights_loaded when a full frame is in place.
- Services the ANN's request_coef/coef_select handshake by reloading the weight matrix from the stream for later layers.

Parameters:
- IMAGE_SIZE, 64, number of 16-bit image words per frame; also the row length of the weight matrix.
- FIRST_LAYER, 16, number of weight rows (nodes).
- CNT_W, 11, width of the word counter; must hold FIRST_LAYER*IMAGE_SIZE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new frame (image then weights).
- data_in  in  16  stream word.
- data_valid  in  1  data_in is valid this cycle.
- data_ready  out  1  loader accepts data_in this cycle.
- request_coef  in  1  ANN requests a weight reload for the next layer.
- coef_select  in  1  layer bank tag sampled with request_coef.
- image  out  16 x IMAGE_SIZE  registered image vector.
- weights  out  16 x FIRST_LAYER x IMAGE_SIZE  registered weight matrix.
- image_weights_loaded  out  1  one-cycle pulse; frame complete.
- coef_loaded  out  1  one-cycle pulse; reload complete.
- coef_bank  out  1  coef_select value latched for the current weight contents.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky; a request arrived in an illegal state. Cleared by rst or by start.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; word_cnt=0.
  - All image and weights entries 0.
  - data_ready, image_weights_loaded, coef_loaded, coef_bank, busy, err all 0.
- A word transfers on a rising edge when data_valid & data_ready. data_ready is a registered function of state only: 1 in LOAD_IMG and LOAD_W, 0 otherwise.
- IDLE:
  - start -> LOAD_IMG, word_cnt=0, err cleared.
  - request_coef -> err set; stay in IDLE.
- LOAD_IMG:
  - Each transfer writes image[word_cnt] and increments word_cnt.
  - The transfer with word_cnt==IMAGE_SIZE-1 -> LOAD_W, word_cnt=0.
- LOAD_W:
  - Transfer k writes weights[k / IMAGE_SIZE][k % IMAGE_SIZE], row-major: node index outer, input index inner.
  - The transfer with word_cnt==FIRST_LAYER*IMAGE_SIZE-1 -> FRAME_DONE if entered from LOAD_IMG, RELOAD_DONE if entered from HOLD. A reload flag records the entry path.
- FRAME_DONE: image_weights_loaded=1 for exactly this one cycle -> HOLD.
- RELOAD_DONE: coef_loaded=1 for exactly this one cycle -> HOLD.
- HOLD:
  - Arrays stable; data_ready=0.
  - request_coef -> LOAD_W with reload flag set, word_cnt=0; coef_bank <= coef_select in the same edge. The image array is untouched.
  - start -> LOAD_IMG (new frame). coef_bank resets to 0.
  - start and request_coef in the same cycle: start wins; err set.
- Latency:
  - First image word accepted one cycle after start.
  - The pulse appears the cycle after the last accepted word.
  - Zero-bubble acceptance when data_valid is held high: a full frame takes 1 + IMAGE_SIZE + FIRST_LAYER*IMAGE_SIZE + 1 cycles from start to pulse.
- start during LOAD_IMG or LOAD_W: abort and restart at LOAD_IMG with word_cnt=0; err set. Partially written entries keep their stale values until overwritten.
- request_coef during LOAD_IMG, LOAD_W, FRAME_DONE or RELOAD_DONE: ignored; err set.
- data_valid while data_ready=0: word is not consumed; no state change.
- rst asserted mid-load: immediate return to reset values; no pulse is emitted.
- Counter never wraps: state transitions on the final index, so word_cnt never exceeds its terminal value.
- Outputs image and weights are driven directly from registers; no combinational path from data_in.

Test Plan:
1. Reset, start, stream image words 0..63 then weight words 1000..2023 with data_valid held high -> data_ready high from the cycle after start; image[5]=5; weights[2][3]=1000+131=1131; image_weights_loaded pulses exactly once, on cycle 1090 after start; busy stays high afterwards (HOLD).
2. Same frame but data_valid toggles 1/0 every cycle -> identical array contents; pulse arrives 1088 cycles later than in scenario 1; no word is skipped or duplicated.
3. From HOLD, request_coef=1 with coef_select=1, stream 1024 words of value 0x7FFF -> all weights = 0x7FFF; image unchanged from scenario 1; coef_bank=1; coef_loaded pulses once; image_weights_loaded stays 0.
4. start, then a second start after 10 image words -> err=1; word_cnt restarts; the next 64 words land at image[0..63]; the frame completes normally.
5. rst asserted for one cycle during LOAD_W at word 500 -> all outputs return to 0 asynchronously; no pulse; a subsequent start completes a full frame correctly.
6. request_coef while in IDLE -> err=1, state remains IDLE, data_ready=0; a following start clears err.
